pe_mac_driver: RTL and testbench

Sequencer that drives one `pe_core` processing element through a complete dot-product job. It clears the PE accumulator and streams `cfg_len` operand pairs from an upstream valid/ready source as single-cycle `read_in` pulses. It then collects the final PE sum on `out_vld` and presents it downstream on a valid/ready result port. It sits between the operand buffer and the PE, and is the initiator side of the PE's pulse/valid interface.

---
 rtl/pe_mac_driver_if.sv | 36 +++
 rtl/pe_mac_driver.sv | 137 +++++++++++++
 tb/tb_pe_mac_driver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_mac_driver_if.sv
// Operand stream, PE pulse/valid link and result stream for pe_mac_driver.
// master: the driver side (accepts operands, drives the PE, offers results).
// slave : the environment side (operand source, PE, result sink).
interface pe_mac_driver_if;
  // Operand pair stream (valid/ready)
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_a;
  logic signed [7:0] in_b;

  // Processing element link
  logic              pe_clr;
  logic              pe_read_in;
  logic              pe_mode_sel;
  logic [7:0]        pe_a;
  logic signed [7:0] pe_b;
  logic              pe_out_vld;
  logic signed [23:0] pe_sum;

  // Result stream (valid/ready)
  logic              res_valid;
  logic              res_ready;
  logic signed [23:0] res_data;

  modport master (
    input  in_valid, in_a, in_b, pe_out_vld, pe_sum, res_ready,
    output in_ready, pe_clr, pe_read_in, pe_mode_sel, pe_a, pe_b,
           res_valid, res_data
  );

  modport slave (
    output in_valid, in_a, in_b, pe_out_vld, pe_sum, res_ready,
    input  in_ready, pe_clr, pe_read_in, pe_mode_sel, pe_a, pe_b,
           res_valid, res_data
  );
endinterface

// File: rtl/pe_mac_driver.sv
// pe_mac_driver: runs one pe_core through a dot-product job. Clears the PE,
// streams cfg_len operand pairs as read_in pulses, captures the final PE sum
// and offers it on a valid/ready result port.
// Ports: clk, reset (async, active-high), start/cfg_len/cfg_relu job setup,
//   busy status, bus (pe_mac_driver_if.master: operand stream, PE link,
//   result stream). Optional stall_cnt (16 b) when PE_DRV_STALL_CNT_EN is
//   defined: FEED cycles with no valid operand, saturating, cleared on start.
module pe_mac_driver #(
  parameter int K_MAX = 64,
  parameter int CNT_W = $clog2(K_MAX + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             cfg_relu,
  output logic             busy,
`ifdef PE_DRV_STALL_CNT_EN
  output logic [15:0]      stall_cnt,
`endif
  pe_mac_driver_if.master  bus
);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, RESULT} state_t;

  localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(K_MAX);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] tap_cnt;
  logic [CNT_W-1:0] vld_cnt;
  logic [CNT_W-1:0] tap_inc;
  logic [CNT_W-1:0] vld_inc;
  logic [CNT_W-1:0] len_clamped;
  logic             start_acc;
  logic             in_fire;
  logic             last_tap;
  logic             vld_seen;
  logic             last_vld;

  assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  assign tap_inc     = tap_cnt + ONE;
  assign vld_inc     = vld_cnt + ONE;
  assign start_acc   = (state == IDLE) && start;
  assign in_fire     = (state == FEED) && bus.in_valid;
  assign last_tap    = in_fire && (tap_inc == len_q);
  // PE results can start arriving while later taps are still being fed,
  // so valid pulses are counted in FEED as well as DRAIN.
  assign vld_seen    = bus.pe_out_vld && ((state == FEED) || (state == DRAIN));
  assign last_vld    = vld_seen && (vld_inc == len_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b1;
    bus.in_ready  = 1'b0;
    bus.res_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = CLEAR;
      end
      CLEAR: begin
        state_nxt = (len_q != '0) ? FEED : RESULT;
      end
      FEED: begin
        bus.in_ready = 1'b1;
        if (last_tap) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_vld) state_nxt = RESULT;
      end
      RESULT: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q           <= '0;
      tap_cnt         <= '0;
      vld_cnt         <= '0;
      bus.pe_clr      <= 1'b0;
      bus.pe_read_in  <= 1'b0;
      bus.pe_mode_sel <= 1'b0;
      bus.pe_a        <= '0;
      bus.pe_b        <= '0;
      bus.res_data    <= '0;
    end else begin
      bus.pe_clr     <= start_acc;
      bus.pe_read_in <= in_fire;
      // Zero operands between taps so pe_sum shows the bare accumulator.
      bus.pe_a       <= in_fire ? bus.in_a : '0;
      bus.pe_b       <= in_fire ? bus.in_b : '0;

      if (start_acc) begin
        len_q           <= len_clamped;
        bus.pe_mode_sel <= cfg_relu;
        tap_cnt         <= '0;
        vld_cnt         <= '0;
      end
      if (in_fire)  tap_cnt <= tap_inc;
      if (vld_seen) vld_cnt <= vld_inc;

      if ((state == CLEAR) && (len_q == '0)) begin
        bus.res_data <= '0;
      end
      if ((state == DRAIN) && last_vld) begin
        bus.res_data <= bus.pe_sum;
      end
    end
  end

`ifdef PE_DRV_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if ((state == FEED) && !bus.in_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_mac_driver.sv
module tb_pe_mac_driver;
  localparam int K_MAX = 64;
  localparam int CNT_W = $clog2(K_MAX + 1);

  logic             clk;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] cfg_len;
  logic             cfg_relu;
  logic             busy;
`ifdef PE_DRV_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  pe_mac_driver_if bus ();

  pe_mac_driver #(.K_MAX(K_MAX), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cfg_len  (cfg_len),
    .cfg_relu (cfg_relu),
    .busy     (busy),
`ifdef PE_DRV_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Simple PE: accumulator cleared by reset or pe_clr, one-cycle valid after
  // each read_in pulse, ReLU applied on the presented sum.
  logic signed [23:0] pe_acc;
  logic signed [23:0] pe_ea;
  logic signed [23:0] pe_eb;
  assign pe_ea = {16'd0, bus.pe_a};
  assign pe_eb = {{16{bus.pe_b[7]}}, bus.pe_b};
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_acc         <= '0;
      bus.pe_out_vld <= 1'b0;
    end else if (bus.pe_clr) begin
      pe_acc         <= '0;
      bus.pe_out_vld <= 1'b0;
    end else begin
      bus.pe_out_vld <= bus.pe_read_in;
      if (bus.pe_read_in) pe_acc <= pe_acc + pe_ea * pe_eb;
    end
  end
  assign bus.pe_sum = (bus.pe_mode_sel && (pe_acc < 0)) ? 24'sd0 : pe_acc;

  // Scoreboard
  logic [23:0] exp_q[$];
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];

  logic               held;
  logic signed [23:0] held_val;
  always @(negedge clk) begin
    if (!reset && bus.res_valid) begin
      if (held) check("res_stable", {40'd0, bus.res_data}, {40'd0, held_val});
      held     <= 1'b1;
      held_val <= bus.res_data;
      if (bus.res_ready) begin
        held <= 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_result", {40'd0, bus.res_data}, 64'hDEAD_BEEF);
        end else begin
          check("res_data", {40'd0, bus.res_data}, {40'd0, exp_q.pop_front()});
        end
      end
    end else begin
      held <= 1'b0;
    end
  end

  function automatic logic [63:0] outv();
    return {18'd0, busy, bus.in_ready, bus.pe_clr, bus.pe_read_in, bus.pe_mode_sel,
            bus.pe_a, bus.pe_b, bus.res_valid, bus.res_data};
  endfunction

  task automatic add_pair(input int a, input int b);
    qa.push_back(8'(a));
    qb.push_back(8'(b));
  endtask

  // One job: stall_mode 0 = none, 1 = alternate cycles, 2 = random.
  task automatic run_job(input int len, input bit relu, input int stall_mode,
                         input int bp, input bit noise);
    int eff, s, idx, cyc, first_vld, bp_left, clr_n, rd_n, idle_bad, stall_n, budget;
    bit done, stall, fire;
    eff = (len > K_MAX) ? K_MAX : len;
    while (qa.size() < eff) add_pair(int'($urandom_range(255)), int'($urandom_range(255)));
    s = 0;
    for (int i = 0; i < eff; i++) s += int'(qa[i]) * int'($signed(qb[i]));
    if (relu && s < 0) s = 0;
    exp_q.push_back(s[23:0]);

    start = 1'b1; cfg_len = CNT_W'(len); cfg_relu = relu;
    bus.in_valid = 1'b0; bus.res_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 1; first_vld = -1; bp_left = bp; clr_n = 0; rd_n = 0;
    idle_bad = 0; stall_n = 0; done = 0;
    budget = 4 * eff + bp + 100;
    while (!done && cyc < budget) begin
      stall = (idx >= eff) || (stall_mode == 1 && (cyc % 2) == 1) ||
              (stall_mode == 2 && $urandom_range(99) < 30);
      bus.in_valid  = !stall;
      bus.in_a      = stall ? 8'($urandom) : qa[idx];
      bus.in_b      = stall ? 8'($urandom) : qb[idx];
      bus.res_ready = (bp_left == 0);
      start         = noise && ($urandom_range(9) == 0);
      cfg_len       = CNT_W'($urandom_range(127));
      cfg_relu      = 1'($urandom);
      @(negedge clk);
      if (bus.pe_clr) clr_n++;
      if (bus.pe_read_in) rd_n++;
      else if (bus.pe_a != 0 || bus.pe_b != 0) idle_bad++;
      fire = bus.in_valid && bus.in_ready;
      if (cyc >= 2 && idx < eff && !bus.in_valid) stall_n++;
      if (bus.res_valid) begin
        if (first_vld < 0) first_vld = cyc;
        if (bp_left > 0) bp_left--;
        else done = 1;
      end
      @(posedge clk); #1;
      cyc++;
      if (fire) idx++;
    end
    start = 1'b0; bus.in_valid = 1'b0; bus.res_ready = 1'b0;
    if (!done) check("job_timeout", 64'(cyc), 64'(budget) + 1);
    check("clr_pulses", 64'(clr_n), 64'd1);
    check("read_pulses", 64'(rd_n), 64'(eff));
    check("idle_operands", 64'(idle_bad), 64'd0);
    check("mode_sel", {63'd0, bus.pe_mode_sel}, {63'd0, relu});
    if (stall_mode == 0) check("latency", 64'(first_vld), (eff == 0) ? 64'd2 : 64'(eff + 4));
`ifdef PE_DRV_STALL_CNT_EN
    check("stall_cnt", {48'd0, stall_cnt}, 64'(stall_n));
`endif
    @(negedge clk);
    check("busy_after_job", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    qa.delete();
    qb.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; cfg_len = '0; cfg_relu = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outv(), 64'd0);
`ifdef PE_DRV_STALL_CNT_EN
    check("reset_stall_cnt", {48'd0, stall_cnt}, 64'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_outputs", outv(), 64'd0);
    @(posedge clk); #1;

    // Basic job
    add_pair(10, 5); add_pair(20, -3); add_pair(255, 127);
    run_job(3, 0, 0, 0, 0);

    // ReLU then the same pairs raw
    add_pair(100, -100); add_pair(1, 50);
    run_job(2, 1, 0, 0, 0);
    add_pair(100, -100); add_pair(1, 50);
    run_job(2, 0, 0, 0, 0);

    // Zero length
    run_job(0, 0, 0, 0, 0);

    // Alternate stalls plus held result
    add_pair(7, -8); add_pair(200, 3); add_pair(0, 99); add_pair(128, -128);
    run_job(4, 0, 1, 5, 0);

    // Back-to-back jobs
    add_pair(50, 50); add_pair(60, 60);
    run_job(2, 0, 0, 0, 0);
    add_pair(1, 2); add_pair(3, -4);
    run_job(2, 0, 0, 0, 0);

    // Oversized length clamps to K_MAX
    run_job(100, 0, 0, 0, 0);
    run_job(K_MAX, 1, 0, 2, 1);

    // Abort after 2 of 5 taps
    start = 1'b1; cfg_len = CNT_W'(5); cfg_relu = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_a = 8'd9; bus.in_b = 8'd7;
    @(posedge clk); #1;
    bus.in_a = 8'd11; bus.in_b = 8'd13;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("abort_outputs", outv(), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle", outv(), 64'd0);
    @(posedge clk); #1;
    add_pair(3, 4);
    run_job(1, 0, 0, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 25; j++) begin
      run_job(int'($urandom_range(70)), 1'($urandom), int'($urandom_range(2)),
              int'($urandom_range(6)), 1'b1);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
